id_ex_stage: RTL and testbench

ID/EX pipeline register of the 5-stage RV32 pipeline, with integrated load-use hazard detection.
- Captures decoded operands and control from ID.
- Drives the EX-stage rs1/rs2/rd addresses consumed by the forwarding unit.
- Inserts a bubble and holds PC and IF/ID when a load in EX feeds the instruction in ID.
- Handles branch flush and downstream memory stall.
- Keeps saturating event counters.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/id_ex_stage_hazard_detect.sv | 37 +++
 rtl/id_ex_stage.sv | 178 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the RV32 pipeline registers.
//               ctrl_t packs the decoded control bundle carried from ID to EX.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int CTRL_W = 12;

    // Bit order (MSB first): regwrite, memread, memwrite, memtoreg, alusrc,
    // branch, jump, aluop[4:0]
    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic [4:0] aluop;
    } ctrl_t;

    localparam ctrl_t      CTRL_NOP = '0;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use detector. Flags when the instruction
//               in EX is a load whose destination is a source actually read
//               by the instruction waiting in ID.
// Ports       : ex_valid_i, ex_memread_i, ex_rd_i   - EX-stage load info
//               id_valid_i, id_rs*_i, id_uses_rs*_i - ID-stage source info
//               load_use_o                          - stall-for-one-cycle flag
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    output logic       load_use_o
);

    logic w_ex_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign w_ex_load  = ex_valid_i & ex_memread_i & (ex_rd_i != REG_ZERO) & id_valid_i;
    assign w_rs1_hit  = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
    assign w_rs2_hit  = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
    assign load_use_o = w_ex_load & (w_rs1_hit | w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use bubble insertion,
//               branch flush, downstream memory stall and saturating event
//               counters.
// Ports       : clk, rst                 - clock, sync active-high reset
//               id_*_i                   - decoded instruction from ID
//               ex_flush_i, mem_stall_i  - pipeline control
//               ex_*_o                   - registered EX-stage fields
//               hold_if_id_o             - freeze PC and IF/ID (combinational)
//               load_use_cnt_o, flush_cnt_o - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CNT_W  = 16,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic [4:0]        id_rd_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              ex_flush_i,
    input  logic              mem_stall_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [4:0]        ex_rs1_o,
    output logic [4:0]        ex_rs2_o,
    output logic [4:0]        ex_rd_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              hold_if_id_o,
    output logic [CNT_W-1:0]  load_use_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              valid_q,    valid_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [4:0]        rs1_q,      rs1_d;
    logic [4:0]        rs2_q,      rs2_d;
    logic [4:0]        rd_q,       rd_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q,      imm_d;
    logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
    logic [CNT_W-1:0]  lu_cnt_q,   lu_cnt_d;
    logic [CNT_W-1:0]  fl_cnt_q,   fl_cnt_d;

    ctrl_t w_ex_ctrl;
    logic  w_load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign w_ex_ctrl = ctrl_t'(ctrl_q);

    hazard_detect u_hazard_detect (
        .ex_valid_i    (valid_q),
        .ex_memread_i  (w_ex_ctrl.memread),
        .ex_rd_i       (rd_q),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_uses_rs1_i (id_uses_rs1_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .load_use_o    (w_load_use)
    );

    // A flush kills the dependent instruction anyway, so it must not also
    // freeze IF/ID; the front end is redirected externally.
    assign hold_if_id_o = mem_stall_i | (w_load_use & ~ex_flush_i);

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        ctrl_d     = ctrl_q;
        lu_cnt_d   = lu_cnt_q;
        fl_cnt_d   = fl_cnt_q;

        if (mem_stall_i) begin
            // everything holds
        end else if (ex_flush_i || w_load_use) begin
            // Bubble: all fields zeroed so the forwarding unit cannot match a
            // dead slot (rd/rs1/rs2 = x0) and no side effects reach EX.
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_d      = REG_ZERO;
            rs2_d      = REG_ZERO;
            rd_d       = REG_ZERO;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            ctrl_d     = CTRL_NOP;
            if (ex_flush_i) begin
                fl_cnt_d = sat_inc(fl_cnt_q);
            end else begin
                lu_cnt_d = sat_inc(lu_cnt_q);
            end
        end else begin
            valid_d    = id_valid_i;
            pc_d       = id_pc_i;
            rs1_data_d = id_rs1_data_i;
            rs2_data_d = id_rs2_data_i;
            imm_d      = id_imm_i;
            // An empty ID slot must not look like a writer or a reader.
            rs1_d      = id_valid_i ? id_rs1_i  : REG_ZERO;
            rs2_d      = id_valid_i ? id_rs2_i  : REG_ZERO;
            rd_d       = id_valid_i ? id_rd_i   : REG_ZERO;
            ctrl_d     = id_valid_i ? id_ctrl_i : CTRL_NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= REG_ZERO;
            rs2_q      <= REG_ZERO;
            rd_q       <= REG_ZERO;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            ctrl_q     <= CTRL_NOP;
            lu_cnt_q   <= '0;
            fl_cnt_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            ctrl_q     <= ctrl_d;
            lu_cnt_q   <= lu_cnt_d;
            fl_cnt_q   <= fl_cnt_d;
        end
    end

    assign ex_valid_o     = valid_q;
    assign ex_pc_o        = pc_q;
    assign ex_rs1_o       = rs1_q;
    assign ex_rs2_o       = rs2_q;
    assign ex_rd_o        = rd_q;
    assign ex_rs1_data_o  = rs1_data_q;
    assign ex_rs2_data_o  = rs2_data_q;
    assign ex_imm_o       = imm_q;
    assign ex_ctrl_o      = ctrl_q;
    assign load_use_cnt_o = lu_cnt_q;
    assign flush_cnt_o    = fl_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Scoreboard bench for id_ex_stage. The driver applies one
//               directed vector per cycle and queues its expected result;
//               the monitor checks hold_if_id in the same cycle and the
//               registered EX fields after the following edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int CW = 8;

    localparam logic [11:0] C_ADD = 12'h801;  // regwrite, aluop=1
    localparam logic [11:0] C_LW  = 12'hD80;  // regwrite, memread, memtoreg, alusrc

    typedef struct packed {
        logic        rst, stall, flush, valid, u1, u2;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, d1, d2, imm;
        logic [11:0] ctrl;
    } vec_t;

    typedef struct packed {
        logic        chk_hold, hold, valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, d1, d2, imm;
        logic [11:0] ctrl;
        logic [CW-1:0] lu, fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_uses_rs1, id_uses_rs2, ex_flush, mem_stall;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [11:0] id_ctrl;
    logic        ex_valid, hold_if_id;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [11:0] ex_ctrl;
    logic [CW-1:0] load_use_cnt, flush_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t last;
    bit   done = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(CW), .CTRL_W(12)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid),
        .id_pc_i        (id_pc),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_rd_i        (id_rd),
        .id_uses_rs1_i  (id_uses_rs1),
        .id_uses_rs2_i  (id_uses_rs2),
        .id_rs1_data_i  (id_rs1_data),
        .id_rs2_data_i  (id_rs2_data),
        .id_imm_i       (id_imm),
        .id_ctrl_i      (id_ctrl),
        .ex_flush_i     (ex_flush),
        .mem_stall_i    (mem_stall),
        .ex_valid_o     (ex_valid),
        .ex_pc_o        (ex_pc),
        .ex_rs1_o       (ex_rs1),
        .ex_rs2_o       (ex_rs2),
        .ex_rd_o        (ex_rd),
        .ex_rs1_data_o  (ex_rs1_data),
        .ex_rs2_data_o  (ex_rs2_data),
        .ex_imm_o       (ex_imm),
        .ex_ctrl_o      (ex_ctrl),
        .hold_if_id_o   (hold_if_id),
        .load_use_cnt_o (load_use_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    // ---------------- vector / expectation builders ----------------
    function automatic vec_t mk(input logic v, input logic [31:0] pc,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic u1,
                                input logic u2, input logic [11:0] ctrl);
        vec_t x;
        x = '0;
        x.valid = v;   x.pc  = pc;  x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
        x.u1    = u1;  x.u2  = u2;  x.ctrl = ctrl;
        x.d1    = pc ^ 32'hA5A5_0000;
        x.d2    = pc ^ 32'h5A5A_0000;
        x.imm   = pc + 32'h40;
        return x;
    endfunction

    // Normal capture of an ID vector.
    function automatic exp_t cap(input vec_t v, input logic hold,
                                 input logic [CW-1:0] lu, input logic [CW-1:0] fl);
        exp_t e;
        e = '0;
        e.chk_hold = 1'b1; e.hold = hold; e.lu = lu; e.fl = fl;
        e.valid = v.valid; e.pc = v.pc;
        e.d1 = v.d1; e.d2 = v.d2; e.imm = v.imm;
        e.rs1  = v.valid ? v.rs1  : 5'd0;
        e.rs2  = v.valid ? v.rs2  : 5'd0;
        e.rd   = v.valid ? v.rd   : 5'd0;
        e.ctrl = v.valid ? v.ctrl : 12'd0;
        return e;
    endfunction

    function automatic exp_t bub(input logic chk, input logic hold,
                                 input logic [CW-1:0] lu, input logic [CW-1:0] fl);
        exp_t e;
        e = '0;
        e.chk_hold = chk; e.hold = hold; e.lu = lu; e.fl = fl;
        return e;
    endfunction

    task automatic step(input vec_t v, input exp_t e);
        @(posedge clk);
        #2;
        rst = v.rst; mem_stall = v.stall; ex_flush = v.flush;
        id_valid = v.valid; id_pc = v.pc; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_rd = v.rd; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm; id_ctrl = v.ctrl;
        sb.push_back(e);
        last = e;
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t pend;
        bit   have_pend;
        have_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (have_pend) begin
                chk("ex_valid", {31'd0, ex_valid}, {31'd0, pend.valid});
                chk("ex_rs1", {27'd0, ex_rs1}, {27'd0, pend.rs1});
                chk("ex_rs2", {27'd0, ex_rs2}, {27'd0, pend.rs2});
                chk("ex_rd", {27'd0, ex_rd}, {27'd0, pend.rd});
                chk("ex_rs1_data", ex_rs1_data, pend.d1);
                chk("ex_rs2_data", ex_rs2_data, pend.d2);
                chk("ex_imm", ex_imm, pend.imm);
                chk("ex_ctrl", {20'd0, ex_ctrl}, {20'd0, pend.ctrl});
                chk("load_use_cnt", {24'd0, load_use_cnt}, {24'd0, pend.lu});
                chk("flush_cnt", {24'd0, flush_cnt}, {24'd0, pend.fl});
                if (pend.valid) chk("ex_pc", ex_pc, pend.pc);
                have_pend = 1'b0;
            end
            if (sb.size() > 0) begin
                pend = sb.pop_front();
                if (pend.chk_hold)
                    chk("hold_if_id", {31'd0, hold_if_id}, {31'd0, pend.hold});
                have_pend = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        vec_t v, vadd, vlw;
        exp_t e;
        int   lu;

        rst = 1'b1; mem_stall = 1'b0; ex_flush = 1'b0; id_valid = 1'b0;
        id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_ctrl = '0;

        // Reset: state unknown beforehand, so hold is only checked once state is clean.
        v = '0; v.rst = 1'b1;
        step(v, bub(1'b0, 1'b0, 0, 0));
        step(v, bub(1'b1, 1'b0, 0, 0));

        // Normal flow
        v = mk(1, 32'h100, 5'd1, 5'd2, 5'd5, 1, 1, C_ADD);
        step(v, cap(v, 0, 0, 0));
        // lw x7 enters EX
        v = mk(1, 32'h104, 5'd3, 5'd0, 5'd7, 1, 0, C_LW);
        step(v, cap(v, 0, 0, 0));
        // Dependent add: bubble, hold, count
        vadd = mk(1, 32'h108, 5'd7, 5'd4, 5'd8, 1, 1, C_ADD);
        step(vadd, bub(1'b1, 1'b1, 1, 0));
        // Held add proceeds with ex_rs1=7
        step(vadd, cap(vadd, 0, 1, 0));

        // Load to x0 followed by a reader of x0: no bubble
        v = mk(1, 32'h10C, 5'd5, 5'd0, 5'd0, 1, 0, C_LW);
        step(v, cap(v, 0, 1, 0));
        v = mk(1, 32'h110, 5'd0, 5'd6, 5'd9, 1, 1, C_ADD);
        step(v, cap(v, 0, 1, 0));

        // rs2 matches but is not used: no bubble
        v = mk(1, 32'h114, 5'd1, 5'd0, 5'd7, 1, 0, C_LW);
        step(v, cap(v, 0, 1, 0));
        v = mk(1, 32'h118, 5'd1, 5'd7, 5'd10, 1, 0, C_ADD);
        step(v, cap(v, 0, 1, 0));

        // Flush wins over load-use
        v = mk(1, 32'h11C, 5'd2, 5'd0, 5'd7, 1, 0, C_LW);
        step(v, cap(v, 0, 1, 0));
        v = mk(1, 32'h120, 5'd7, 5'd0, 5'd11, 1, 0, C_ADD);
        v.flush = 1'b1;
        step(v, bub(1'b1, 1'b0, 1, 1));

        // mem_stall for 3 cycles with flush and load-use pending
        v = mk(1, 32'h124, 5'd1, 5'd0, 5'd12, 1, 0, C_LW);
        e = cap(v, 0, 1, 1);
        step(v, e);
        v = mk(1, 32'h128, 5'd12, 5'd0, 5'd13, 1, 0, C_ADD);
        v.stall = 1'b1; v.flush = 1'b1;
        e.hold = 1'b1;
        for (int i = 0; i < 3; i++) step(v, e);
        // Stall drops, flush applies
        v.stall = 1'b0;
        step(v, bub(1'b1, 1'b0, 1, 2));

        // Saturation: 2^CW+5 load-use events
        lu = 1;
        for (int i = 0; i < (1 << CW) + 5; i++) begin
            vlw = mk(1, 32'h1000 + 8 * i, 5'd1, 5'd0, 5'd7, 1, 0, C_LW);
            step(vlw, cap(vlw, 0, lu[CW-1:0], 2));
            lu = (lu >= (1 << CW) - 1) ? (1 << CW) - 1 : lu + 1;
            vadd = mk(1, 32'h1004 + 8 * i, 5'd4, 5'd7, 5'd8, 0, 1, C_ADD);
            step(vadd, bub(1'b1, 1'b1, lu[CW-1:0], 2));
        end
        step(vadd, cap(vadd, 0, 8'hFF, 2));

        // Reset during stall
        v = mk(1, 32'h200, 5'd1, 5'd0, 5'd7, 1, 0, C_LW);
        step(v, cap(v, 0, 8'hFF, 2));
        v = mk(1, 32'h204, 5'd7, 5'd0, 5'd3, 1, 0, C_ADD);
        v.stall = 1'b1; v.flush = 1'b1; v.rst = 1'b1;
        step(v, bub(1'b0, 1'b0, 0, 0));
        v.rst = 1'b0;
        step(v, bub(1'b1, 1'b1, 0, 0));

        // Empty ID slot: control and addresses forced to zero
        v = mk(0, 32'h300, 5'd7, 5'd2, 5'd3, 1, 1, C_ADD);
        step(v, cap(v, 0, 0, 0));
        v = mk(1, 32'h304, 5'd6, 5'd2, 5'd3, 1, 1, C_ADD);
        step(v, cap(v, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
